regfile_legv8: RTL

//   32 x 64-bit LEGv8 register file that sources operands A and B for ALU_LEGv8.

---
 rtl/regfile_legv8.sv | 85 ++++++++
 1 files changed

// File: rtl/regfile_legv8.sv
// regfile_legv8: 32 x 64-bit LEGv8 register file with a 4-bit {V,C,N,Z} flag register.
// Two combinational read ports, one synchronous write port, optional write-to-read
// forwarding, and a hard-wired zero register (XZR).
module regfile_legv8 #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 31,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            status_in,
    input  logic                  flag_en,
    output logic [3:0]            flags
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [3:0]            flags_q;
    logic [3:0]            flags_d;
    logic                  write_hit;

    // Writes aimed at XZR are dropped so that entry stays zero forever.
    assign write_hit = write_en && (write_addr != ZERO_ADDR);

    // Register array: async clear, otherwise load the addressed entry on a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_hit) begin
            regs_q[write_addr] <= write_data;
        end
    end

    // Flag next-state: load ALU status on S-suffix instructions, otherwise hold.
    always_comb begin
        flags_d = flags_q;
        if (flag_en) begin
            flags_d = status_in;
        end
    end

    // Flag register: async clear, never forwarded to the output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

    // Port A: XZR wins over forwarding, forwarding wins over the stored value.
    always_comb begin
        A = regs_q[read_addr_a];
        if (read_addr_a == ZERO_ADDR) begin
            A = '0;
        end else if (BYPASS && write_en && (write_addr == read_addr_a)) begin
            A = write_data;
        end
    end

    // Port B: same priority as port A, fully independent of it.
    always_comb begin
        B = regs_q[read_addr_b];
        if (read_addr_b == ZERO_ADDR) begin
            B = '0;
        end else if (BYPASS && write_en && (write_addr == read_addr_b)) begin
            B = write_data;
        end
    end

endmodule
